// File: rtl/act_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : act_feeder
//  Purpose  : Activation feeder for one systolic block row. Buffers packed
//             activation words from the loader in a local FIFO and answers
//             each row-controller write request with a burst of
//             cfg_burst_len beats on the actbuf write channel. Up to three
//             requests may be queued; a dropped request raises ovf_err.
//  Revision : 1.0  initial release
// ============================================================================
module act_feeder #(
  parameter int DATA_W     = 32,  // two ACTBUF_DATA_LEN lanes packed per beat
  parameter int FIFO_DEPTH = 16,  // power of two, >= 4
  parameter int BL_W       = 10
) (
  input  logic              clk_l,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [BL_W-1:0]   cfg_burst_len,
  input  logic              actbuf_wr_req,
  output logic              actbuf_wr_vld,
  output logic [DATA_W-1:0] actbuf_wr_data,
  output logic              busy,
  output logic              ovf_err
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     C_FULL    = (AW+1)'(FIFO_DEPTH);
  localparam logic [BL_W-1:0] C_LAST    = BL_W'(1);
  localparam logic [1:0]      C_PEND_MX = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  // Request queue, burst sequencing and output stage
  logic [0:0]        r_state;
  logic [0:0]        w_next_state;
  logic [1:0]        r_pend;
  logic [BL_W-1:0]   r_beat;
  logic              r_vld;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;

  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_req;
  logic w_dec;   // a queued request is claimed this cycle
  logic w_load;  // beat counter reloads from cfg_burst_len this cycle

  // in_rdy follows only the registered count; a same-cycle pop does not help
  assign w_full = (r_count == C_FULL);
  assign in_rdy = !w_full;
  assign w_push = in_vld && !w_full;
  assign w_req  = actbuf_wr_req && (cfg_burst_len != '0);

  assign actbuf_wr_vld  = r_vld;
  assign actbuf_wr_data = r_data;
  assign busy           = (r_state == ST_BURST) || (r_pend != 2'd0);
  assign ovf_err        = r_ovf;

  // FIFO storage write; contents are simply abandoned by a pointer reset
  always_ff @(posedge clk_l) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next state: enter BURST on a queued request, leave after the last
  // beat only when nothing else is queued
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 2'd0) w_next_state = ST_BURST;
      end
      ST_BURST: begin
        if ((r_count != '0) && (r_beat == C_LAST) && (r_pend == 2'd0))
          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: pop while bursting with data available, claim queued requests
  always_comb begin
    w_pop  = 1'b0;
    w_dec  = 1'b0;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend != 2'd0) begin
          w_dec  = 1'b1;
          w_load = 1'b1;
        end
      end
      ST_BURST: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if ((r_beat == C_LAST) && (r_pend != 2'd0)) begin
            w_dec  = 1'b1;
            w_load = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Beat counter: loaded at each burst start, counts down per pop
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n)      r_beat <= '0;
    else if (w_load) r_beat <= cfg_burst_len;
    else if (w_pop)  r_beat <= r_beat - 1'b1;
  end

  // Pending-request counter with sticky overflow on a dropped request
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 2'd0;
      r_ovf  <= 1'b0;
    end else begin
      case ({w_req, w_dec})
        2'b10: begin
          if (r_pend == C_PEND_MX) r_ovf  <= 1'b1;
          else                     r_pend <= r_pend + 2'd1;
        end
        2'b01:   r_pend <= r_pend - 2'd1;
        default: r_pend <= r_pend;
      endcase
    end
  end

  // Registered beat output; data holds its last value between beats
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      r_vld <= w_pop;
      if (w_pop) r_data <= r_mem[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_act_feeder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_act_feeder
//  Purpose  : Self-checking bench for act_feeder: directed vector table,
//             directed multi-cycle sequences and a randomized phase, all
//             compared against a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_act_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BLW   = 10;

  logic           clk_l = 1'b0;
  logic           rst_n = 1'b0;
  logic [DW-1:0]  in_data = '0;
  logic           in_vld = 1'b0;
  logic           in_rdy;
  logic [BLW-1:0] cfg_burst_len = '0;
  logic           actbuf_wr_req = 1'b0;
  logic           actbuf_wr_vld;
  logic [DW-1:0]  actbuf_wr_data;
  logic           busy;
  logic           ovf_err;

  int total = 0;
  int bad   = 0;

  act_feeder #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .BL_W(BLW)) dut (
    .clk_l          (clk_l),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .cfg_burst_len  (cfg_burst_len),
    .actbuf_wr_req  (actbuf_wr_req),
    .actbuf_wr_vld  (actbuf_wr_vld),
    .actbuf_wr_data (actbuf_wr_data),
    .busy           (busy),
    .ovf_err        (ovf_err)
  );

  always #5 clk_l = ~clk_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: a word queue, a pending-request count and the number
  // of beats still owed by the burst in progress.
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_q [$];
  int            m_pend;
  bit            m_active;
  int            m_rem;
  bit            m_vld;
  logic [DW-1:0] m_data;
  bit            m_ovf;

  task automatic model_step();
    int  sz   = m_q.size();
    bit  pop  = m_active && (sz > 0);
    bit  take = in_vld && (sz < DEPTH);
    bit  cnt  = actbuf_wr_req && (cfg_burst_len != 0);
    bit  start = 1'b0;
    if (!m_active) begin
      if (m_pend > 0) begin
        m_active = 1'b1;
        m_rem    = int'(cfg_burst_len);
        start    = 1'b1;
      end
    end else if (pop) begin
      m_rem--;
      if (m_rem == 0) begin
        if (m_pend > 0) begin
          m_rem = int'(cfg_burst_len);
          start = 1'b1;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    if (cnt && !start) begin
      if (m_pend == 3) m_ovf = 1'b1;
      else             m_pend++;
    end else if (start && !cnt) begin
      m_pend--;
    end
    m_vld = pop;
    if (pop)  m_data = m_q.pop_front();
    if (take) m_q.push_back(in_data);
  endtask

  always @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pend   = 0;
      m_active = 1'b0;
      m_rem    = 0;
      m_vld    = 1'b0;
      m_data   = '0;
      m_ovf    = 1'b0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model
  bit chk_en = 1'b0;
  always @(negedge clk_l) begin
    if (chk_en) begin
      check("model",
            {28'd0, actbuf_wr_vld, actbuf_wr_data, busy, ovf_err, in_rdy},
            {28'd0, m_vld, m_data, (m_active || m_pend > 0), m_ovf, (m_q.size() < DEPTH)});
    end
  end

  // Beat monitor with cycle stamps
  int            cyc = 0;
  logic [DW-1:0] beats [$];
  int            beat_cyc [$];
  always @(posedge clk_l) cyc++;
  always @(negedge clk_l) begin
    if (actbuf_wr_vld) begin
      beats.push_back(actbuf_wr_data);
      beat_cyc.push_back(cyc);
    end
  end

  // Drive one word and hold it until accepted (inputs change on negedges)
  task automatic push_hold(input logic [DW-1:0] w);
    bit acc;
    in_vld  = 1'b1;
    in_data = w;
    for (int c = 0; c < 200; c++) begin
      acc = in_rdy;
      @(negedge clk_l);
      actbuf_wr_req = 1'b0;
      if (acc) begin
        in_vld = 1'b0;
        return;
      end
    end
    in_vld = 1'b0;
    check("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_req(input logic [BLW-1:0] len);
    cfg_burst_len = len;
    actbuf_wr_req = 1'b1;
    @(negedge clk_l);
    actbuf_wr_req = 1'b0;
  endtask

  typedef struct {
    bit            vld;
    logic [DW-1:0] din;
    bit            req;
    logic [BLW-1:0] len;
    bit            e_vld;
    logic [DW-1:0] e_data;
    bit            e_busy;
    bit            e_ovf;
    bit            e_rdy;
  } vec_t;

  vec_t tv [11];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int sz;
    logic [DW-1:0] exp_w;

    // Basic burst: preload A0..A3, one request of 4 beats
    tv[0]  = '{1'b1, 32'hA0, 1'b0, 10'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
    tv[1]  = '{1'b1, 32'hA1, 1'b0, 10'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 32'hA2, 1'b0, 10'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 32'hA3, 1'b0, 10'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 32'h0,  1'b1, 10'd4, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1};
    tv[6]  = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b1, 32'hA2, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b0, 32'h0,  1'b0, 10'd4, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk_l);
    check("reset_state", {28'd0, actbuf_wr_vld, actbuf_wr_data, busy, ovf_err, in_rdy},
          {28'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_l);

    for (int i = 0; i < 11; i++) begin
      in_vld        = tv[i].vld;
      in_data       = tv[i].din;
      actbuf_wr_req = tv[i].req;
      cfg_burst_len = tv[i].len;
      @(negedge clk_l);
      check($sformatf("vec%0d", i),
            {28'd0, actbuf_wr_vld, actbuf_wr_data, busy, ovf_err, in_rdy},
            {28'd0, tv[i].e_vld, tv[i].e_data, tv[i].e_busy, tv[i].e_ovf, tv[i].e_rdy});
    end
    in_vld = 1'b0;
    actbuf_wr_req = 1'b0;

    // Starvation: request first, then one word every three cycles
    pulse_req(10'd3);
    repeat (3) @(negedge clk_l);
    check("starve_busy", {63'd0, busy}, 64'd1);
    check("starve_novld", {63'd0, actbuf_wr_vld}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      exp_w = 32'hB0 + k;
      push_hold(exp_w);
      check($sformatf("starve%0d_gap", k), {63'd0, actbuf_wr_vld}, 64'd0);
      @(negedge clk_l);
      check($sformatf("starve%0d_beat", k), {31'd0, actbuf_wr_vld, actbuf_wr_data}, {31'd0, 1'b1, exp_w});
      @(negedge clk_l);
      check($sformatf("starve%0d_after", k), {62'd0, actbuf_wr_vld, busy}, {62'd0, 1'b0, (k < 2)});
    end

    // Back-to-back: 6 words, three 2-beat requests on consecutive cycles
    beats.delete();
    beat_cyc.delete();
    for (int k = 0; k < 6; k++) push_hold(32'hC0 + k);
    cfg_burst_len = 10'd2;
    actbuf_wr_req = 1'b1;
    repeat (3) @(negedge clk_l);
    actbuf_wr_req = 1'b0;
    repeat (15) @(negedge clk_l);
    check("b2b_count", beats.size(), 64'd6);
    if (beats.size() == 6) begin
      for (int k = 0; k < 6; k++) check($sformatf("b2b_word%0d", k), beats[k], 32'hC0 + k);
      check("b2b_contig", beat_cyc[5] - beat_cyc[0], 64'd5);
    end
    check("b2b_idle", {62'd0, busy, ovf_err}, 64'd0);

    // Overflow: one stalled burst plus four more requests
    beats.delete();
    pulse_req(10'd2);
    repeat (3) @(negedge clk_l);
    cfg_burst_len = 10'd2;
    for (int k = 0; k < 4; k++) begin
      actbuf_wr_req = 1'b1;
      @(negedge clk_l);
      actbuf_wr_req = 1'b0;
      check($sformatf("ovf_req%0d", k), {63'd0, ovf_err}, {63'd0, (k == 3)});
    end
    for (int k = 0; k < 10; k++) push_hold(32'hD0 + k);
    repeat (20) @(negedge clk_l);
    check("ovf_beats", beats.size(), 64'd8);
    check("ovf_sticky", {62'd0, ovf_err, busy}, {62'd0, 1'b1, 1'b0});

    // FIFO full and pointer wrap: drain leftovers, fill, then a 20-beat burst
    pulse_req(10'd2);
    repeat (6) @(negedge clk_l);
    beats.delete();
    for (int k = 0; k < DEPTH; k++) push_hold(32'h10 + k);
    check("full_rdy", {63'd0, in_rdy}, 64'd0);
    cfg_burst_len = 10'd20;
    actbuf_wr_req = 1'b1;
    for (int k = 0; k < 4; k++) push_hold(32'h100 + k);
    repeat (30) @(negedge clk_l);
    check("wrap_count", beats.size(), 64'd20);
    if (beats.size() == 20) begin
      for (int k = 0; k < 20; k++) begin
        exp_w = (k < DEPTH) ? 32'h10 + k : 32'h100 + (k - DEPTH);
        check($sformatf("wrap_word%0d", k), beats[k], exp_w);
      end
    end
    check("wrap_idle", {62'd0, busy, in_rdy}, 64'd1);

    // Zero-length request is ignored
    beats.delete();
    pulse_req(10'd0);
    repeat (3) @(negedge clk_l);
    check("zero_len", {31'd0, busy, beats.size()}, 64'd0);

    // Asynchronous reset after two beats of a 5-beat burst
    for (int k = 0; k < 5; k++) push_hold(32'hE0 + k);
    pulse_req(10'd5);
    n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      @(negedge clk_l);
      if (actbuf_wr_vld) n++;
    end
    check("rst_two_beats", n, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {28'd0, actbuf_wr_vld, actbuf_wr_data, busy, ovf_err, in_rdy},
          {28'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1});
    sz = beats.size();
    repeat (2) @(negedge clk_l);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_l);
    check("rst_no_more", beats.size(), sz);
    check("rst_idle", {62'd0, busy, in_rdy}, 64'd1);

    // Randomized traffic against the model, then drain
    for (int c = 0; c < 1500; c++) begin
      in_vld        = ($urandom_range(0, 99) < 60);
      in_data       = $urandom;
      actbuf_wr_req = ($urandom_range(0, 99) < 8);
      cfg_burst_len = BLW'($urandom_range(0, 6));
      @(negedge clk_l);
    end
    actbuf_wr_req = 1'b0;
    for (int c = 0; c < 200; c++) begin
      in_vld  = 1'b1;
      in_data = $urandom;
      @(negedge clk_l);
    end
    in_vld = 1'b0;
    repeat (5) @(negedge clk_l);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
